// File: rtl/smpl_io_bridge_pkg.sv
// Shared constants for the SMPL core I/O bridge: address map, STATUS and ERR layouts.
package smpl_io_bridge_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 13;

  localparam logic [ADDR_W-1:0] ADDR_TX_DATA = 13'h1FFC;
  localparam logic [ADDR_W-1:0] ADDR_RX_DATA = 13'h1FFD;
  localparam logic [ADDR_W-1:0] ADDR_STATUS  = 13'h1FFE;
  localparam logic [ADDR_W-1:0] ADDR_ERR     = 13'h1FFF;

  localparam int unsigned ST_TX_FULL     = 0;
  localparam int unsigned ST_TX_EMPTY    = 1;
  localparam int unsigned ST_RX_NONEMPTY = 2;
  localparam int unsigned ST_RX_FULL     = 3;
  localparam int unsigned ST_TX_CNT_LSB  = 4;
  localparam int unsigned ST_RX_CNT_LSB  = 8;
  localparam int unsigned ST_CNT_W       = 3;

  localparam int unsigned ERR_TX_OVF   = 0;
  localparam int unsigned ERR_RX_UNF   = 1;
  localparam int unsigned ERR_UNMAPPED = 2;
  localparam int unsigned ERR_W        = 3;

  // Assemble the STATUS word; unused bits read as zero.
  function automatic logic [DATA_W-1:0] pack_status(
    input logic                tx_full,
    input logic                tx_empty,
    input logic                rx_nonempty,
    input logic                rx_full,
    input logic [ST_CNT_W-1:0] tx_cnt,
    input logic [ST_CNT_W-1:0] rx_cnt
  );
    logic [DATA_W-1:0] s;
    s                               = '0;
    s[ST_TX_FULL]                   = tx_full;
    s[ST_TX_EMPTY]                  = tx_empty;
    s[ST_RX_NONEMPTY]               = rx_nonempty;
    s[ST_RX_FULL]                   = rx_full;
    s[ST_TX_CNT_LSB +: ST_CNT_W]    = tx_cnt;
    s[ST_RX_CNT_LSB +: ST_CNT_W]    = rx_cnt;
    return s;
  endfunction

endpackage

// File: rtl/smpl_io_bridge_fifo.sv
// Small synchronous FIFO; push is ignored when full and pop when empty.
module smpl_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               wdata_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               rdata_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointer and occupancy update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/smpl_io_bridge.sv
// Core data-port bridge: data RAM plus memory-mapped TX/RX FIFOs, STATUS and sticky ERR.
module smpl_io_bridge
  import smpl_io_bridge_pkg::*;
#(
  parameter int unsigned RAM_DEPTH  = 256,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_daddr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_renbl,
  input  logic              cpu_wenbl,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready
);

  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  logic              wr_en, rd_en;
  logic              sel_ram, sel_tx, sel_rx, sel_status, sel_err, sel_unmapped;
  logic              tx_push, tx_pop, tx_full, tx_empty;
  logic              rx_push, rx_pop, rx_full, rx_empty;
  logic [CNT_W-1:0]  tx_count, rx_count;
  logic [DATA_W-1:0] rx_head, status_word;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [DATA_W-1:0] ram_q [RAM_DEPTH];

  // A write always wins; a concurrent read is suppressed entirely.
  assign wr_en = cpu_wenbl;
  assign rd_en = cpu_renbl & ~cpu_wenbl;

  assign sel_tx       = (cpu_daddr == ADDR_TX_DATA);
  assign sel_rx       = (cpu_daddr == ADDR_RX_DATA);
  assign sel_status   = (cpu_daddr == ADDR_STATUS);
  assign sel_err      = (cpu_daddr == ADDR_ERR);
  assign sel_ram      = (32'(cpu_daddr) < RAM_DEPTH);
  assign sel_unmapped = ~(sel_ram | sel_tx | sel_rx | sel_status | sel_err);

  always_ff @(posedge clock) begin
    if (wr_en && sel_ram) ram_q[cpu_daddr[RAM_AW-1:0]] <= cpu_wdata;
  end

  assign tx_valid = ~tx_empty;
  assign tx_push  = wr_en & sel_tx & ~tx_full;
  assign tx_pop   = tx_valid & tx_ready;

  smpl_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (tx_push),
    .wdata_i (cpu_wdata),
    .pop_i   (tx_pop),
    .rdata_o (tx_data),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  assign rx_ready = ~rx_full;
  assign rx_push  = rx_valid & rx_ready;
  assign rx_pop   = rd_en & sel_rx & ~rx_empty;

  smpl_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (rx_push),
    .wdata_i (rx_data),
    .pop_i   (rx_pop),
    .rdata_o (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  assign status_word = pack_status(tx_full, tx_empty, ~rx_empty, rx_full,
                                   ST_CNT_W'(tx_count), ST_CNT_W'(rx_count));

  // Clear is applied before new events so a coincident event keeps its flag set.
  always_comb begin
    err_d = err_q;
    if (wr_en && sel_err)                 err_d = err_q & ~cpu_wdata[ERR_W-1:0];
    if (wr_en && sel_tx && tx_full)       err_d[ERR_TX_OVF]   = 1'b1;
    if (rd_en && sel_rx && rx_empty)      err_d[ERR_RX_UNF]   = 1'b1;
    if ((wr_en || rd_en) && sel_unmapped) err_d[ERR_UNMAPPED] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) err_q <= '0;
    else       err_q <= err_d;
  end

  // Load data mux; anything not listed (TX_DATA, unmapped, empty RX) reads zero.
  always_comb begin
    cpu_rdata = '0;
    if (rd_en) begin
      if (sel_ram)                 cpu_rdata = ram_q[cpu_daddr[RAM_AW-1:0]];
      else if (sel_rx && !rx_empty) cpu_rdata = rx_head;
      else if (sel_status)         cpu_rdata = status_word;
      else if (sel_err)            cpu_rdata = DATA_W'(err_q);
    end
  end

endmodule

// File: doc/smpl_io_bridge.md
SMPL_IO_BRIDGE -- requirements
Module: smpl_io_bridge

Interface
REQ-001 SHALL have parameter RAM_DEPTH, default 256: number of 16-bit data RAM words, mapped at address 0x0000 and up.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: entries in each of the TX and RX FIFOs; a power of two, at most 4.
REQ-003 clock  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cpu_daddr  input  13  data address from the core.
REQ-006 cpu_wdata  input  16  store data from the core.
REQ-007 cpu_renbl  input  1  read enable from the core.
REQ-008 cpu_wenbl  input  1  write enable from the core.
REQ-009 cpu_rdata  output  16  load data to the core; combinational, valid in the same cycle.
REQ-010 tx_data  output  16  TX FIFO head word to the external consumer.
REQ-011 tx_valid  output  1  TX FIFO not empty.
REQ-012 tx_ready  input  1  external consumer accepts tx_data.
REQ-013 rx_data  input  16  word from the external producer.
REQ-014 rx_valid  input  1  rx_data is valid.
REQ-015 rx_ready  output  1  RX FIFO not full.

Function
REQ-016 Address map SHALL be:
- RAM: 0x0000 to RAM_DEPTH-1.
- TX_DATA: 0x1FFC.
- RX_DATA: 0x1FFD.
- STATUS: 0x1FFE.
- ERR: 0x1FFF.
- All other addresses unmapped.
REQ-017 A write is performed when cpu_wenbl=1; a read when cpu_renbl=1 and cpu_wenbl=0. When both are high, the write wins and the read has no side effects.
REQ-018 RAM write: the word is stored at the clock edge; RAM reads are combinational, with no latency.
REQ-019 TX_DATA write with the TX FIFO not full: push cpu_wdata at the clock edge.
REQ-020 TX_DATA write with the TX FIFO full: drop the word and set ERR[0] (tx overflow). Fullness is sampled before the same-cycle external pop.
REQ-021 TX FIFO pop: when tx_valid and tx_ready are both high at the clock edge. Push and pop in the same cycle leave the count unchanged.
REQ-022 RX push: when rx_valid and rx_ready are both high at the clock edge. rx_ready is derived from the count before the same-cycle core pop.
REQ-023 RX_DATA read, FIFO not empty: cpu_rdata = head; pop at the clock edge.
REQ-024 RX_DATA read, FIFO empty: cpu_rdata = 0, no pop, set ERR[1] (rx underflow).
REQ-025 STATUS read SHALL return:
- bit0 tx_full
- bit1 tx_empty
- bit2 rx_nonempty
- bit3 rx_full
- [6:4] tx_count
- [10:8] rx_count
- other bits 0
REQ-026 STATUS writes SHALL be ignored.
REQ-027 ERR read SHALL return the sticky flags in [2:0], other bits 0. An ERR write SHALL clear each flag whose cpu_wdata bit is 1 (write-1-to-clear).
REQ-028 If a clear and a new error event hit the same flag in the same cycle, the flag SHALL end up set.
REQ-029 An unmapped read returns 0; an unmapped read or write sets ERR[2] and has no other effect.
REQ-030 cpu_rdata SHALL be 0 when no read is performed. A TX_DATA read returns 0 with no side effect.
REQ-031 FIFO pointers SHALL wrap modulo FIFO_DEPTH. Counts SHALL be FIFO_DEPTH+1 states wide, and neither FIFO SHALL overflow or underflow internally.

Reset
REQ-032 On reset SHALL:
- empty both FIFOs and zero all counts and pointers;
- clear ERR;
- drive tx_valid=0, rx_ready=1, cpu_rdata=0 (no read active).
REQ-033 RAM contents SHALL NOT be reset. A reset asserted mid-transfer SHALL discard all FIFO contents and complete no handshake.

Structure
REQ-034 A shared package SHALL define:
- address constants: TX_DATA, RX_DATA, STATUS, ERR;
- STATUS bit positions;
- ERR bit positions.
REQ-035 One sub-module, smpl_fifo (parameterized width and depth, push/pop/full/empty/count), SHALL be instantiated twice, once for TX and once for RX.

Verification
REQ-036 RAM: write 0xBEEF to 0x0010, then read 0x0010. Required: cpu_rdata=0xBEEF in the read cycle.
REQ-037 TX fill, tx_ready=0: write 0x0001..0x0005 to 0x1FFC. Required: STATUS[6:4]=4, tx_full=1, ERR[0]=1. Then hold tx_ready=1 for 4 cycles. Required: tx_data sequence 1,2,3,4, then tx_valid=0.
REQ-038 RX: push 0xA5A5 via rx_valid, then read 0x1FFD twice. Required: first read returns 0xA5A5, second read returns 0 and sets ERR[1]. Then write 0x0002 to 0x1FFF. Required: ERR=0.
REQ-039 Simultaneous events:
- TX full, core write and tx_ready=1 in the same cycle. Required: word dropped, count goes to 3, ERR[0]=1.
- RX FIFO at 3 entries, push and pop in the same cycle. Required: count stays 3.
REQ-040 Mid-operation reset: with 2 TX and 3 RX entries, assert reset asynchronously. Required: tx_valid=0, rx_ready=1, STATUS=0x0002, ERR=0 immediately.
REQ-041 Unmapped access: read 0x0800. Required: cpu_rdata=0, ERR[2]=1, no FIFO or RAM change.
